// File: rtl/rom_reader_pkg.sv
// Shared constants for the PROM dump logic: chip types, last addresses,
// chip-select patterns and the sequencer state encoding.
package rom_reader_pkg;

  localparam logic CHIP_IP3601 = 1'b0;
  localparam logic CHIP_IP3604 = 1'b1;

  localparam int IP3601_LAST_ADDR = 255;
  localparam int IP3604_LAST_ADDR = 511;

  localparam logic [3:0] CS_IDLE   = 4'b1111;
  localparam logic [3:0] CS_IP3601 = 4'b1110;
  localparam logic [3:0] CS_IP3604 = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_OUTPUT,
`ifdef ROM_DUMP_CHECKSUM_EN
    ST_CSUM_LO,
    ST_CSUM_HI,
`endif
    ST_DONE
  } seq_state_t;

  function automatic logic [3:0] cs_pattern(input logic chip);
    return (chip == CHIP_IP3604) ? CS_IP3604 : CS_IP3601;
  endfunction

endpackage

// File: rtl/rom_dump_sequencer_if.sv
// Bundle of PROM socket pins, control strobes and the word-stream handshake
// between the dump sequencer (master) and its environment (slave).
interface rom_dump_sequencer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9
);

  logic                     start;
  logic                     abort;
  logic                     selected_chip;
  logic [DATA_WIDTH-1:0]    chip_data_port;
  logic [ADDRESS_WIDTH-1:0] chip_address_port;
  logic [3:0]               chip_selection_port;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_valid;
  logic                     data_ready;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, abort, selected_chip, chip_data_port, data_ready,
    output chip_address_port, chip_selection_port, data_out, data_valid, busy, done
  );

  modport slave (
    output start, abort, selected_chip, chip_data_port, data_ready,
    input  chip_address_port, chip_selection_port, data_out, data_valid, busy, done
  );

endinterface

// File: rtl/rom_settle_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module rom_settle_timer #(
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  output logic               done
);

  logic [COUNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Walks every PROM address, waits for the bus to settle, captures and streams
// each word. Optional trailing 16-bit checksum under ROM_DUMP_CHECKSUM_EN.
module rom_dump_sequencer
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rom_dump_sequencer_if.master bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IP3601 = ADDRESS_WIDTH'(IP3601_LAST_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IP3604 = ADDRESS_WIDTH'(IP3604_LAST_ADDR);

  seq_state_t state;
  logic       chip_sel;
  logic       xfer;
  logic       at_last;
  logic       timer_load;
  logic       timer_done;

  // The 4-bit IP3601 leaves the upper data lines floating; never pass them on.
  function automatic logic [DATA_WIDTH-1:0] mask_word(input logic chip,
                                                      input logic [DATA_WIDTH-1:0] raw);
    return (chip == CHIP_IP3601) ? {{(DATA_WIDTH-4){1'b0}}, raw[3:0]} : raw;
  endfunction

  assign xfer    = bus.data_valid && bus.data_ready;
  assign at_last = (bus.chip_address_port == (chip_sel ? LAST_IP3604 : LAST_IP3601));

  // Reload the timer whenever an address is (re)driven onto the socket.
  assign timer_load = !bus.abort &&
                      (((state == ST_IDLE) && bus.start) ||
                       ((state == ST_OUTPUT) && xfer && !at_last));

  rom_settle_timer #(.COUNT_W(CW)) u_settle_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (SETTLE_LOAD),
    .done       (timer_done)
  );

`ifdef ROM_DUMP_CHECKSUM_EN
  logic [15:0] csum;
  logic [15:0] csum_next;

  assign csum_next = csum + 16'(bus.data_out);

  function automatic logic [DATA_WIDTH-1:0] csum_word(input logic [7:0] b);
    return DATA_WIDTH'(b);
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= ST_IDLE;
      chip_sel                <= 1'b0;
      bus.chip_address_port   <= '0;
      bus.chip_selection_port <= CS_IDLE;
      bus.data_out            <= '0;
      bus.data_valid          <= 1'b0;
      bus.busy                <= 1'b0;
      bus.done                <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
      csum                    <= '0;
`endif
    end else if (bus.abort) begin
      state                   <= ST_IDLE;
      bus.chip_address_port   <= '0;
      bus.chip_selection_port <= CS_IDLE;
      bus.data_valid          <= 1'b0;
      bus.busy                <= 1'b0;
      bus.done                <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            chip_sel                <= bus.selected_chip;
            bus.chip_address_port   <= '0;
            bus.chip_selection_port <= cs_pattern(bus.selected_chip);
            bus.busy                <= 1'b1;
            state                   <= ST_SETTLE;
`ifdef ROM_DUMP_CHECKSUM_EN
            csum                    <= '0;
`endif
          end
        end
        ST_SETTLE: begin
          if (timer_done) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          bus.data_out   <= mask_word(chip_sel, bus.chip_data_port);
          bus.data_valid <= 1'b1;
          state          <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (xfer) begin
            if (at_last) begin
              bus.chip_address_port   <= '0;
              bus.chip_selection_port <= CS_IDLE;
`ifdef ROM_DUMP_CHECKSUM_EN
              csum                    <= csum_next;
              bus.data_out            <= csum_word(csum_next[7:0]);
              state                   <= ST_CSUM_LO;
`else
              bus.data_valid          <= 1'b0;
              bus.done                <= 1'b1;
              state                   <= ST_DONE;
`endif
            end else begin
`ifdef ROM_DUMP_CHECKSUM_EN
              csum                  <= csum_next;
`endif
              bus.data_valid        <= 1'b0;
              bus.chip_address_port <= bus.chip_address_port + 1'b1;
              state                 <= ST_SETTLE;
            end
          end
        end
`ifdef ROM_DUMP_CHECKSUM_EN
        ST_CSUM_LO: begin
          if (xfer) begin
            bus.data_out <= csum_word(csum[15:8]);
            state        <= ST_CSUM_HI;
          end
        end
        ST_CSUM_HI: begin
          if (xfer) begin
            bus.data_valid <= 1'b0;
            bus.done       <= 1'b1;
            state          <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Directed bench for rom_dump_sequencer with a small PROM model on the socket pins.
module tb_rom_dump_sequencer;

  localparam int S = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   rom_mode    = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_count  = 0;

  always #5 clk = ~clk;

  rom_dump_sequencer_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(9)) bus ();

  rom_dump_sequencer #(
    .DATA_WIDTH    (8),
    .ADDRESS_WIDTH (9),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // PROM model: mode 0 = addr^A5, mode 1 = constant F3, otherwise all ones.
  always_comb begin
    case (rom_mode)
      0:       bus.chip_data_port = bus.chip_address_port[7:0] ^ 8'hA5;
      1:       bus.chip_data_port = 8'hF3;
      default: bus.chip_data_port = 8'hFF;
    endcase
  end

  always @(negedge clk) if (bus.done === 1'b1) done_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_word(input int mode, input int addr);
    logic [7:0] a;
    a = 8'(addr);
    case (mode)
      0:       return a ^ 8'hA5;
      1:       return 8'h03;
      default: return 8'h0F;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    repeat (64) begin
      tick();
      cyc++;
      if (bus.data_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_start(input logic chip);
    bus.selected_chip = chip;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic run_dump(input logic chip, input int mode, input int n);
    logic [7:0] w;
    logic [3:0] cs_exp;
    int cyc;
    bit ok;
    int d0;
`ifdef ROM_DUMP_CHECKSUM_EN
    logic [15:0] sum;
    sum = '0;
`endif
    cs_exp = chip ? 4'b1100 : 4'b1110;
    rom_mode = mode;
    d0 = done_count;
    bus.data_ready = 1'b1;
    do_start(chip);
    for (int i = 0; i < n; i++) begin
      wait_valid(cyc, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL dump_timeout addr %0d: valid never rose", i);
        return;
      end
      w = exp_word(mode, i);
`ifdef ROM_DUMP_CHECKSUM_EN
      sum = sum + 16'(w);
`endif
      vectors++;
      if (bus.data_out !== w || bus.chip_address_port !== 9'(i) ||
          bus.chip_selection_port !== cs_exp || cyc != ((i == 0) ? S + 1 : S + 2)) begin
        miscompares++;
        $display("FAIL dump_word %0d: data %h addr %0d cs %b lat %0d, want %h %0d %b %0d",
                 i, bus.data_out, bus.chip_address_port, bus.chip_selection_port, cyc,
                 w, i, cs_exp, (i == 0) ? S + 1 : S + 2);
      end
    end
    tick();
`ifdef ROM_DUMP_CHECKSUM_EN
    vectors++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== sum[7:0] || bus.chip_selection_port !== 4'b1111) begin
      miscompares++;
      $display("FAIL csum_lo: valid %b data %h cs %b, want 1 %h 1111",
               bus.data_valid, bus.data_out, bus.chip_selection_port, sum[7:0]);
    end
    tick();
    vectors++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== sum[15:8]) begin
      miscompares++;
      $display("FAIL csum_hi: valid %b data %h, want 1 %h", bus.data_valid, bus.data_out, sum[15:8]);
    end
    tick();
`endif
    vectors++;
    if (bus.done !== 1'b1 || bus.chip_selection_port !== 4'b1111 ||
        bus.data_valid !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL dump_done: done %b cs %b valid %b busy %b, want 1 1111 0 1",
               bus.done, bus.chip_selection_port, bus.data_valid, bus.busy);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || done_count != d0 + 1) begin
      miscompares++;
      $display("FAIL dump_idle: done %b busy %b pulses %0d, want 0 0 1",
               bus.done, bus.busy, done_count - d0);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.chip_address_port !== 9'd0 || bus.chip_selection_port !== 4'b1111 ||
        bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: addr %0d cs %b data %h valid %b busy %b done %b",
               bus.chip_address_port, bus.chip_selection_port, bus.data_out,
               bus.data_valid, bus.busy, bus.done);
    end
  endtask

  task automatic test_ip3604_dump();
    run_dump(1'b1, 0, 512);
  endtask

  task automatic test_ip3601_dump();
    run_dump(1'b0, 1, 256);
  endtask

  task automatic test_ready_low();
    int cyc;
    bit ok;
    rom_mode = 0;
    bus.data_ready = 1'b1;
    do_start(1'b1);
    for (int i = 0; i < 8; i++) wait_valid(cyc, ok);
    bus.data_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA2 || bus.chip_address_port !== 9'd7) begin
        miscompares++;
        $display("FAIL ready_low_hold cyc %0d: valid %b data %h addr %0d, want 1 a2 7",
                 k, bus.data_valid, bus.data_out, bus.chip_address_port);
      end
    end
    bus.data_ready = 1'b1;
    wait_valid(cyc, ok);
    vectors++;
    if (!ok || bus.data_out !== 8'hAD || bus.chip_address_port !== 9'd8) begin
      miscompares++;
      $display("FAIL ready_resume: ok %0d data %h addr %0d, want 1 ad 8",
               ok, bus.data_out, bus.chip_address_port);
    end
    do_abort();
    vectors++;
    if (bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || bus.chip_selection_port !== 4'b1111) begin
      miscompares++;
      $display("FAIL abort_output: valid %b busy %b cs %b, want 0 0 1111",
               bus.data_valid, bus.busy, bus.chip_selection_port);
    end
  endtask

  task automatic test_abort_settle();
    int cyc;
    bit ok;
    int d0;
    rom_mode = 0;
    bus.data_ready = 1'b1;
    do_start(1'b1);
    for (int i = 0; i < 100; i++) wait_valid(cyc, ok);
    tick();
    vectors++;
    if (bus.chip_address_port !== 9'd100 || bus.data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL settle_at_100: addr %0d valid %b, want 100 0", bus.chip_address_port, bus.data_valid);
    end
    d0 = done_count;
    do_abort();
    vectors++;
    if (bus.chip_selection_port !== 4'b1111 || bus.data_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.chip_address_port !== 9'd0) begin
      miscompares++;
      $display("FAIL abort_settle: cs %b valid %b busy %b addr %0d, want 1111 0 0 0",
               bus.chip_selection_port, bus.data_valid, bus.busy, bus.chip_address_port);
    end
    repeat (10) tick();
    vectors++;
    if (done_count != d0 || bus.data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: pulses %0d valid %b, want 0 0", done_count - d0, bus.data_valid);
    end
    do_start(1'b1);
    wait_valid(cyc, ok);
    vectors++;
    if (!ok || bus.chip_address_port !== 9'd0 || bus.data_out !== 8'hA5 || cyc != S + 1) begin
      miscompares++;
      $display("FAIL restart: addr %0d data %h lat %0d, want 0 a5 %0d",
               bus.chip_address_port, bus.data_out, cyc, S + 1);
    end
    do_abort();
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    rom_mode = 0;
    bus.data_ready = 1'b0;
    do_start(1'b1);
    wait_valid(cyc, ok);
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.chip_address_port !== 9'd0 || bus.chip_selection_port !== 4'b1111 ||
        bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: addr %0d cs %b data %h valid %b busy %b done %b",
               bus.chip_address_port, bus.chip_selection_port, bus.data_out,
               bus.data_valid, bus.busy, bus.done);
    end
    tick();
    reset_n = 1'b1;
    bus.data_ready = 1'b1;
    tick();
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit ok;
    rom_mode = 0;
    bus.data_ready = 1'b1;
    do_start(1'b1);
    tick();
    bus.selected_chip = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid(cyc, ok);
    vectors++;
    if (!ok || bus.chip_address_port !== 9'd0 || bus.data_out !== 8'hA5 || bus.chip_selection_port !== 4'b1100) begin
      miscompares++;
      $display("FAIL start_busy_w0: addr %0d data %h cs %b, want 0 a5 1100",
               bus.chip_address_port, bus.data_out, bus.chip_selection_port);
    end
    wait_valid(cyc, ok);
    vectors++;
    if (!ok || bus.chip_address_port !== 9'd1 || bus.data_out !== 8'hA4 || bus.chip_selection_port !== 4'b1100) begin
      miscompares++;
      $display("FAIL start_busy_w1: addr %0d data %h cs %b, want 1 a4 1100",
               bus.chip_address_port, bus.data_out, bus.chip_selection_port);
    end
    do_abort();
    bus.selected_chip = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.chip_selection_port !== 4'b1111) begin
      miscompares++;
      $display("FAIL start_abort_idle: busy %b cs %b, want 0 1111", bus.busy, bus.chip_selection_port);
    end
    repeat (8) tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL start_abort_later: busy %b valid %b, want 0 0", bus.busy, bus.data_valid);
    end
  endtask

`ifdef ROM_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    run_dump(1'b0, 2, 256);
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.selected_chip = 1'b0;
    bus.data_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    tick();
    test_ip3604_dump();
    test_ip3601_dump();
    test_ready_low();
    test_abort_settle();
    test_reset_mid();
    test_start_ignored();
`ifdef ROM_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
